instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly in front of the control unit. It owns the
// program counter, requests instruction words from instruction memory over a
// req/ack handshake, latches the returned word into an instruction register,
// and presents the decoded fields downstream with a valid/ready handshake.
// Branch redirects from execute and a HALT opcode are handled here.
//
// Instruction format (24 bits): [23:16] opcode, [15:12] rd, [11:8] rs1,
// [7:0] imm.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable        allows new fetches to start (never aborts one in flight)
//   imem_req      instruction memory request, held until imem_ack
//   imem_addr     request address, stable while imem_req=1
//   imem_ack      memory accepted request; imem_rdata valid this cycle
//   imem_rdata    instruction word returned by memory
//   instr_valid   opcode/rd/rs1/imm/pc_out are valid
//   instr_ready   downstream accepts the presented instruction
//   opcode        opcode field to the control unit
//   rd            destination register field
//   rs1           source register field
//   imm           immediate field
//   pc_out        address of the presented instruction
//   branch_taken  single-cycle redirect pulse from execute
//   branch_target redirect address
//   halted        HALT opcode consumed (sticky until reset)
//   fetch_error   fetch watchdog expired (sticky until reset)
//
// Configuration macro:
//   FETCH_TIMEOUT_EN  when defined, a watchdog counts cycles spent waiting
//                     for imem_ack; reaching TIMEOUT_CYCLES raises
//                     fetch_error and halts. When undefined no counter is
//                     built, fetch_error is tied low and a fetch may wait
//                     forever.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int         ADDR_WIDTH     = 8,
   parameter int         INSTR_WIDTH    = 24,
   parameter logic [7:0] HALT_OPCODE    = 8'hFF,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [7:0]             opcode,
   output logic [3:0]             rd,
   output logic [3:0]             rs1,
   output logic [7:0]             imm,
   output logic [ADDR_WIDTH-1:0]  pc_out,
   input  logic                   branch_taken,
   input  logic [ADDR_WIDTH-1:0]  branch_target,
   output logic                   halted,
   output logic                   fetch_error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_VALID,
      S_HALTED
   } state_t;

   state_t                 state;
   logic [ADDR_WIDTH-1:0]  pc;
   logic [INSTR_WIDTH-1:0] ir;
   logic                   redirect_pending;
   logic [ADDR_WIDTH-1:0]  redirect_target;
   logic                   timeout_hit;

   // Address the next request should use: a branch arriving in the same
   // cycle a request is launched takes effect immediately.
   logic [ADDR_WIDTH-1:0]  steer_pc;
   assign steer_pc = branch_taken ? branch_target : pc;

   // Fields come straight from the instruction register, so they are stable
   // for as long as the instruction is presented.
   assign opcode = ir[23:16];
   assign rd     = ir[15:12];
   assign rs1    = ir[11:8];
   assign imm    = ir[7:0];

   // --------------------------------------------------------------------------
   // Fetch watchdog
   // --------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] wait_cnt;
   logic             waiting;

   // A cycle counts as waiting only while a request is actually outstanding;
   // the one-cycle request gap after a discarded word does not count.
   assign waiting     = (state == S_FETCH) && imem_req && !imem_ack;
   assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= '0;
         fetch_error <= 1'b0;
      end else begin
         if (timeout_hit) begin
            fetch_error <= 1'b1;
         end
         if (waiting && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign fetch_error = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Fetch control FSM, all outputs registered
   // --------------------------------------------------------------------------
   // NOTE: every register below is assigned with <= so all of them update
   // together from the same pre-edge values; a blocking = here would let later
   // statements see half-updated state and break simulation/synthesis match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         pc               <= '0;
         ir               <= '0;
         pc_out           <= '0;
         imem_req         <= 1'b0;
         imem_addr        <= '0;
         instr_valid      <= 1'b0;
         halted           <= 1'b0;
         redirect_pending <= 1'b0;
         redirect_target  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (branch_taken) begin
                  pc <= branch_target;
               end
               if (enable) begin
                  state     <= S_FETCH;
                  imem_req  <= 1'b1;
                  imem_addr <= steer_pc;
               end
            end

            S_FETCH: begin
               if (!imem_req) begin
                  // Gap cycle after a discarded word: re-issue from the
                  // redirected pc regardless of enable, the fetch is already
                  // committed.
                  imem_req  <= 1'b1;
                  imem_addr <= steer_pc;
                  pc        <= steer_pc;
               end else if (timeout_hit) begin
                  imem_req <= 1'b0;
                  halted   <= 1'b1;
                  state    <= S_HALTED;
               end else if (imem_ack) begin
                  imem_req <= 1'b0;
                  if (branch_taken || redirect_pending) begin
                     // The returned word belongs to the wrong path: drop it.
                     // A branch in this very cycle is newer than any stored
                     // redirect, so it wins.
                     pc               <= branch_taken ? branch_target : redirect_target;
                     redirect_pending <= 1'b0;
                  end else begin
                     ir          <= imem_rdata;
                     pc_out      <= pc;
                     pc          <= pc + ADDR_WIDTH'(1);
                     instr_valid <= 1'b1;
                     state       <= S_VALID;
                  end
               end else if (branch_taken) begin
                  // The memory has the old address in flight; remember where
                  // to go once it answers.
                  redirect_pending <= 1'b1;
                  redirect_target  <= branch_target;
               end
            end

            S_VALID: begin
               if (branch_taken) begin
                  // Flush: the presented instruction is dropped even if
                  // downstream signalled ready in this same cycle.
                  instr_valid <= 1'b0;
                  pc          <= branch_target;
                  if (enable) begin
                     state     <= S_FETCH;
                     imem_req  <= 1'b1;
                     imem_addr <= branch_target;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  if (opcode == HALT_OPCODE) begin
                     halted <= 1'b1;
                     state  <= S_HALTED;
                  end else if (enable) begin
                     state     <= S_FETCH;
                     imem_req  <= 1'b1;
                     imem_addr <= pc;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            S_HALTED: begin
               // Terminal until reset; every input is ignored.
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b1;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Scoreboard bench for instr_fetch_unit. Directed stimulus pushes the expected
// memory request addresses and the expected consumed instructions into queues;
// an independent monitor pops and compares whenever the DUT completes a memory
// handshake (imem_req && imem_ack) or an instruction handshake
// (instr_valid && instr_ready without a same-cycle branch). A small memory
// model answers requests after a programmable number of wait cycles.
//
// Timing: memory model drives on the falling edge, the main sequence drives
// and samples 2 time units later, the monitor samples 3 time units later --
// all well clear of the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam int AW = 8;
   localparam int IW = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [IW-1:0] imem_rdata = '0;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic [7:0]    opcode;
   logic [3:0]    rd;
   logic [3:0]    rs1;
   logic [7:0]    imm;
   logic [AW-1:0] pc_out;
   logic          branch_taken = 1'b0;
   logic [AW-1:0] branch_target = '0;
   logic          halted;
   logic          fetch_error;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0]    op;
      logic [3:0]    rd;
      logic [3:0]    rs1;
      logic [7:0]    imm;
      logic [AW-1:0] pc;
   } instr_exp_t;

   logic [AW-1:0] exp_addr_q[$];
   instr_exp_t    exp_instr_q[$];

   logic [IW-1:0] mem [256];
   int            mem_wait = 0;
   bit            ack_block = 1'b0;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_WIDTH     (AW),
      .INSTR_WIDTH    (IW),
      .HALT_OPCODE    (8'hFF),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .opcode        (opcode),
      .rd            (rd),
      .rs1           (rs1),
      .imm           (imm),
      .pc_out        (pc_out),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halted        (halted),
      .fetch_error   (fetch_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
      #2;
   endtask

   task automatic push_instr(input logic [7:0] op, input logic [3:0] r_d,
                             input logic [3:0] r_s1, input logic [7:0] im,
                             input logic [AW-1:0] pc);
      instr_exp_t e;
      e.op  = op;
      e.rd  = r_d;
      e.rs1 = r_s1;
      e.imm = im;
      e.pc  = pc;
      exp_instr_q.push_back(e);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!instr_valid && n < 20) begin
         nxt();
         n++;
      end
      check({name, "_wait_valid"}, instr_valid, 1);
   endtask

   // Memory model: acknowledges an outstanding request after mem_wait cycles.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
         end else if (imem_req && !imem_ack && !ack_block) begin
            if (wait_cnt >= mem_wait) begin
               imem_ack   = 1'b1;
               imem_rdata = mem[imem_addr];
               wait_cnt   = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            if (!imem_req) wait_cnt = 0;
         end
      end
   end

   // Monitor: compares every completed handshake against the scoreboard.
   initial begin
      instr_exp_t    e;
      logic [AW-1:0] a;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && imem_req && imem_ack) begin
            if (exp_addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got addr %0h expected no request", imem_addr);
            end else begin
               a = exp_addr_q.pop_front();
               check("req_addr", imem_addr, a);
            end
         end
         if (rst_n && instr_valid && instr_ready && !branch_taken) begin
            if (exp_instr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_instr: got pc %0h expected no handshake", pc_out);
            end else begin
               e = exp_instr_q.pop_front();
               check("sb_opcode", opcode, e.op);
               check("sb_rd", rd, e.rd);
               check("sb_rs1", rs1, e.rs1);
               check("sb_imm", imm, e.imm);
               check("sb_pc_out", pc_out, e.pc);
            end
         end
      end
   end

   // Absolute bound on run time.
   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish by 100000");
      $fatal(1, "simulation time limit");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h00] = 24'h020312;
      mem[8'h01] = 24'h114507;
      mem[8'h02] = 24'h22890A;
      mem[8'h03] = 24'h33C1FE;
      mem[8'h04] = 24'h0BADBD;
      mem[8'h40] = 24'h405566;
      mem[8'h50] = 24'hFF0000;
      mem[8'h80] = 24'h80ABCD;
      mem[8'hFF] = 24'h7E1234;

      // ---- reset state ----
      rst_n = 1'b0;
      nxt();
      nxt();
      check("rst_imem_req", imem_req, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_fetch_error", fetch_error, 0);
      check("rst_pc_out", pc_out, 0);
      check("rst_opcode", opcode, 0);
      check("rst_imem_addr", imem_addr, 0);
      rst_n = 1'b1;
      nxt();

      // ---- first fetch, held by instr_ready=0 ----
      exp_addr_q.push_back(8'h00);
      enable = 1'b1;
      instr_ready = 1'b0;
      wait_valid("first");
      for (int i = 0; i < 5; i++) begin
         nxt();
         check("hold_valid", instr_valid, 1);
         check("hold_req", imem_req, 0);
         check("hold_opcode", opcode, 8'h02);
         check("hold_imm", imm, 8'h12);
         check("hold_pc_out", pc_out, 0);
      end

      // ---- zero-wait streaming: one instruction every 2 cycles ----
      push_instr(8'h02, 4'h0, 4'h3, 8'h12, 8'h00);
      push_instr(8'h11, 4'h4, 4'h5, 8'h07, 8'h01);
      push_instr(8'h22, 4'h8, 4'h9, 8'h0A, 8'h02);
      exp_addr_q.push_back(8'h01);
      exp_addr_q.push_back(8'h02);
      exp_addr_q.push_back(8'h03);
      instr_ready = 1'b1;
      check("pulse_0", instr_valid, 1);
      for (int i = 1; i < 6; i++) begin
         int exp_pat;
         exp_pat = (i % 2 == 0) ? 1 : 0;
         nxt();
         check("pulse_n", instr_valid, exp_pat);
      end
      nxt();
      check("pc3_valid", instr_valid, 1);
      check("pc3_pc_out", pc_out, 8'h03);
      instr_ready = 1'b0;
      enable = 1'b0;

      // ---- consume with enable low -> IDLE ----
      push_instr(8'h33, 4'hC, 4'h1, 8'hFE, 8'h03);
      nxt();
      instr_ready = 1'b1;
      nxt();
      instr_ready = 1'b0;
      nxt();
      nxt();
      check("idle_req", imem_req, 0);
      check("idle_valid", instr_valid, 0);

      // ---- delayed ack with redirect in first wait cycle ----
      mem_wait = 3;
      exp_addr_q.push_back(8'h04);
      exp_addr_q.push_back(8'h40);
      enable = 1'b1;
      nxt();
      check("redir_w1_req", imem_req, 1);
      check("redir_w1_addr", imem_addr, 8'h04);
      branch_taken = 1'b1;
      branch_target = 8'h40;
      enable = 1'b0;   // enable low must not abort the committed fetch
      nxt();
      branch_taken = 1'b0;
      check("redir_w2_addr", imem_addr, 8'h04);
      nxt();
      check("redir_w3_addr", imem_addr, 8'h04);
      nxt();
      check("redir_ack_addr", imem_addr, 8'h04);
      check("redir_ack_seen", imem_ack, 1);
      nxt();
      check("redir_discard_valid", instr_valid, 0);
      check("redir_gap_req", imem_req, 0);
      nxt();
      check("redir_reissue_req", imem_req, 1);
      check("redir_reissue_addr", imem_addr, 8'h40);
      wait_valid("redir");
      check("redir_pc_out", pc_out, 8'h40);
      check("redir_opcode", opcode, 8'h40);

      // ---- branch together with instr_ready in VALID ----
      mem_wait = 0;
      enable = 1'b1;
      exp_addr_q.push_back(8'h80);
      instr_ready = 1'b1;
      branch_taken = 1'b1;
      branch_target = 8'h80;
      nxt();
      branch_taken = 1'b0;
      instr_ready = 1'b0;
      check("flush_valid", instr_valid, 0);
      wait_valid("flush");
      check("flush_pc_out", pc_out, 8'h80);
      check("flush_imm", imm, 8'hCD);

      // ---- pc wrap 0xFF -> 0x00 ----
      exp_addr_q.push_back(8'hFF);
      exp_addr_q.push_back(8'h00);
      branch_taken = 1'b1;
      branch_target = 8'hFF;
      nxt();
      branch_taken = 1'b0;
      wait_valid("wrap_ff");
      check("wrap_ff_pc_out", pc_out, 8'hFF);
      push_instr(8'h7E, 4'h1, 4'h2, 8'h34, 8'hFF);
      instr_ready = 1'b1;
      nxt();
      instr_ready = 1'b0;
      wait_valid("wrap_00");
      check("wrap_00_pc_out", pc_out, 8'h00);
      check("wrap_00_opcode", opcode, 8'h02);

      // ---- HALT ----
      exp_addr_q.push_back(8'h50);
      branch_taken = 1'b1;
      branch_target = 8'h50;
      nxt();
      branch_taken = 1'b0;
      wait_valid("halt");
      check("halt_opcode_seen", opcode, 8'hFF);
      push_instr(8'hFF, 4'h0, 4'h0, 8'h00, 8'h50);
      instr_ready = 1'b1;
      nxt();
      instr_ready = 1'b0;
      nxt();
      check("halted_set", halted, 1);
      check("halted_req", imem_req, 0);
      check("halted_valid", instr_valid, 0);
      branch_taken = 1'b1;
      branch_target = 8'h10;
      nxt();
      branch_taken = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nxt();
         check("halted_stay_req", imem_req, 0);
         check("halted_stay", halted, 1);
      end

      // ---- watchdog ----
      rst_n = 1'b0;
      nxt();
      check("rst2_halted", halted, 0);
      ack_block = 1'b1;
      rst_n = 1'b1;
      enable = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 4; i++) nxt();
      check("wd_pre_error", fetch_error, 0);
      check("wd_pre_req", imem_req, 1);
      nxt();
      check("wd_error", fetch_error, 1);
      check("wd_halted", halted, 1);
      check("wd_req", imem_req, 0);
`else
      for (int i = 0; i < 30; i++) nxt();
      check("nowd_error", fetch_error, 0);
      check("nowd_req", imem_req, 1);
      check("nowd_halted", halted, 0);
`endif

      // ---- reset in the middle of an outstanding request ----
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
      nxt();
      nxt();
      check("midrst_pre_req", imem_req, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_req", imem_req, 0);
      check("midrst_valid", instr_valid, 0);
      check("midrst_error", fetch_error, 0);
      check("midrst_halted", halted, 0);
      enable = 1'b0;
      ack_block = 1'b0;
      nxt();
      nxt();

      check("sb_addr_q_empty", exp_addr_q.size(), 0);
      check("sb_instr_q_empty", exp_instr_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
